// File: rtl/hart_0_frontend_pkg.sv
// Shared frontend types for hart 0: fetch entry layout and queue sizing helpers.
package hart_0_frontend_pkg;

  localparam int FQ_PC_W   = 32;
  localparam int FQ_INST_W = 32;
  localparam int FQ_DEPTH  = 4;

  // One buffered fetch response. The queue parameters PC_W/INST_W must match
  // these widths because the storage array is built from this struct.
  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_INST_W-1:0] inst;
    logic                 xcpt;
  } fetch_entry_t;

  // Occupancy counter needs one extra bit so that "full" is representable.
  function automatic int fq_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FQ_COUNT_W = fq_count_w(FQ_DEPTH);

endpackage

// File: rtl/hart_0_fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module hart_0_fetch_queue_ram
  import hart_0_frontend_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the enqueued entry at the tail slot.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hart_0_fetch_queue.sv
// Hart 0 instruction fetch queue: buffers fetch responses (PC, instruction,
// fault flag) between the frontend and decode, drops responses from a stale
// epoch, and holds off further fetches once a faulting entry is queued.
module hart_0_fetch_queue
  import hart_0_frontend_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int PC_W   = FQ_PC_W,
  parameter int INST_W = FQ_INST_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  input  logic [PC_W-1:0]         resp_pc,
  input  logic [INST_W-1:0]       resp_inst,
  input  logic                    resp_xcpt,
  input  logic                    resp_epoch,
  input  logic                    flush,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [PC_W-1:0]         deq_pc,
  output logic [INST_W-1:0]       deq_inst,
  output logic                    deq_xcpt,
  output logic                    cur_epoch,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    fault_hold
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fq_count_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;
  logic             has_head;
  fetch_entry_t     wdata;
  fetch_entry_t     rdata;

  // Ready depends only on registered state so decode stalls never reach the
  // frontend combinationally.
  assign resp_ready = reset_n & (count < CNT_W'(DEPTH)) & ~fault_hold;

  // Stale-epoch responses still complete the handshake but are not written.
  assign enq = resp_valid & resp_ready & (resp_epoch == cur_epoch) & ~flush;

  assign has_head  = (count != '0);
  assign deq_valid = has_head & ~flush;
  assign deq       = deq_valid & deq_ready;

  assign wdata.pc   = resp_pc;
  assign wdata.inst = resp_inst;
  assign wdata.xcpt = resp_xcpt;

  hart_0_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clock (clock),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is unreset, so mask the head data to zero while the queue is empty.
  assign deq_pc   = rdata.pc   & {PC_W{has_head}};
  assign deq_inst = rdata.inst & {INST_W{has_head}};
  assign deq_xcpt = rdata.xcpt & has_head;

  // Pointer, occupancy, epoch and fault-hold bookkeeping; flush wins over all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_epoch  <= 1'b0;
      fault_hold <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_epoch  <= ~cur_epoch;
      fault_hold <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (enq && resp_xcpt) begin
        fault_hold <= 1'b1;
      end
    end
  end

  // Occupancy can never leave [0, DEPTH] given the ready/valid gating above.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(enq && !deq && count == CNT_W'(DEPTH)));

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(deq && count == '0));

endmodule

// File: tb/tb_hart_0_fetch_queue.sv
// Scoreboard bench for hart_0_fetch_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every dequeue handshake.
module tb_hart_0_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        xcpt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_pc = '0;
  logic [31:0] resp_inst = '0;
  logic        resp_xcpt = 1'b0;
  logic        resp_epoch = 1'b0;
  logic        flush = 1'b0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_xcpt;
  logic        cur_epoch;
  logic [2:0]  count;
  logic        fault_hold;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  exp_t sb_q[$];

  hart_0_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pc    (resp_pc),
    .resp_inst  (resp_inst),
    .resp_xcpt  (resp_xcpt),
    .resp_epoch (resp_epoch),
    .flush      (flush),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .deq_pc     (deq_pc),
    .deq_inst   (deq_inst),
    .deq_xcpt   (deq_xcpt),
    .cur_epoch  (cur_epoch),
    .count      (count),
    .fault_hold (fault_hold)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dequeue handshake must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && deq_valid && deq_ready) begin
      pops++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_deq: got pc %0h expected no entry", deq_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("deq_pc", 64'(deq_pc), 64'(e.pc));
        check("deq_inst", 64'(deq_inst), 64'(e.inst));
        check("deq_xcpt", 64'(deq_xcpt), 64'(e.xcpt));
      end
    end
  end

  // Present one response until the queue is ready; returns at posedge+1.
  task automatic send(input logic [31:0] pc, input logic x, input logic ep, input bit exp_enq);
    bit ok;
    exp_t e;
    ok = 0;
    resp_valid = 1'b1;
    resp_pc    = pc;
    resp_inst  = inst_of(pc);
    resp_xcpt  = x;
    resp_epoch = ep;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (resp_ready) begin
        ok = 1;
        if (exp_enq) begin
          e.pc = pc; e.inst = inst_of(pc); e.xcpt = x;
          sb_q.push_back(e);
        end
      end
      @(posedge clock); #1;
    end
    resp_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got resp_ready 0 expected 1 for pc %0h", pc);
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    deq_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (count == 3'd0) done = 1;
      else begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    check({name, "_drained"}, 64'(done), 64'(1));
    check({name, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    check("flush_cycle_deq_valid", 64'(deq_valid), 64'(0));
    @(posedge clock); #1;
    flush = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int p0;

    // Reset values while reset_n is held low.
    #12;
    check("rst_deq_valid", 64'(deq_valid), 64'(0));
    check("rst_resp_ready", 64'(resp_ready), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_epoch", 64'(cur_epoch), 64'(0));
    check("rst_fault_hold", 64'(fault_hold), 64'(0));
    check("rst_deq_pc", 64'(deq_pc), 64'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_resp_ready", 64'(resp_ready), 64'(1));
    @(posedge clock); #1;

    // Fill then drain in order.
    deq_ready = 1'b0;
    send(32'h100, 1'b0, 1'b0, 1);
    send(32'h104, 1'b0, 1'b0, 1);
    send(32'h108, 1'b0, 1'b0, 1);
    send(32'h10C, 1'b0, 1'b0, 1);
    @(negedge clock);
    check("full_count", 64'(count), 64'(4));
    check("full_resp_ready", 64'(resp_ready), 64'(0));
    check("full_deq_valid", 64'(deq_valid), 64'(1));
    @(posedge clock); #1;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("drain_count", 64'(count), 64'(4 - i));
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("drained_deq_valid", 64'(deq_valid), 64'(0));
    check("drained_count", 64'(count), 64'(0));
    check("fill_sb_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clock); #1;

    // Streaming: one enqueue and one dequeue per cycle, occupancy stays at 1.
    p0 = pops;
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      resp_valid = 1'b1;
      resp_pc    = 32'h1000 + 32'(4 * i);
      resp_inst  = inst_of(resp_pc);
      resp_xcpt  = 1'b0;
      resp_epoch = 1'b0;
      @(negedge clock);
      check("stream_resp_ready", 64'(resp_ready), 64'(1));
      check("stream_count", 64'(count), (i == 0) ? 64'(0) : 64'(1));
      e.pc = resp_pc; e.inst = resp_inst; e.xcpt = 1'b0;
      sb_q.push_back(e);
      @(posedge clock); #1;
    end
    resp_valid = 1'b0;
    drain("stream");
    check("stream_pops", 64'(pops - p0), 64'(20));

    // Flush with entries in flight, then stale responses are dropped.
    deq_ready = 1'b0;
    send(32'h180, 1'b0, 1'b0, 1);
    send(32'h184, 1'b0, 1'b0, 1);
    send(32'h188, 1'b0, 1'b0, 1);
    pulse_flush();
    @(negedge clock);
    check("flush_count", 64'(count), 64'(0));
    check("flush_epoch", 64'(cur_epoch), 64'(1));
    @(posedge clock); #1;
    send(32'h18C, 1'b0, 1'b0, 0);
    send(32'h190, 1'b0, 1'b0, 0);
    @(negedge clock);
    check("stale_count", 64'(count), 64'(0));
    check("stale_deq_valid", 64'(deq_valid), 64'(0));
    @(posedge clock); #1;
    send(32'h200, 1'b0, 1'b1, 1);
    drain("epoch1");

    // Fault hold: faulting entry is delivered, further fetches stall until flush.
    deq_ready = 1'b0;
    send(32'h300, 1'b1, 1'b1, 1);
    @(negedge clock);
    check("fault_hold_set", 64'(fault_hold), 64'(1));
    check("fault_resp_ready", 64'(resp_ready), 64'(0));
    @(posedge clock); #1;
    resp_valid = 1'b1; resp_pc = 32'h304; resp_inst = inst_of(32'h304);
    resp_xcpt = 1'b0; resp_epoch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("fault_stall_ready", 64'(resp_ready), 64'(0));
      check("fault_stall_count", 64'(count), 64'(1));
      @(posedge clock); #1;
    end
    resp_valid = 1'b0;
    drain("fault");
    @(negedge clock);
    check("fault_hold_kept", 64'(fault_hold), 64'(1));
    @(posedge clock); #1;
    pulse_flush();
    @(negedge clock);
    check("fault_cleared", 64'(fault_hold), 64'(0));
    check("fault_flush_ready", 64'(resp_ready), 64'(1));
    check("fault_flush_epoch", 64'(cur_epoch), 64'(0));
    @(posedge clock); #1;

    // Flush, response and dequeue all in one cycle.
    deq_ready = 1'b0;
    send(32'h400, 1'b0, 1'b0, 1);
    send(32'h404, 1'b0, 1'b0, 1);
    flush = 1'b1; deq_ready = 1'b1;
    resp_valid = 1'b1; resp_pc = 32'h408; resp_inst = inst_of(32'h408);
    resp_xcpt = 1'b0; resp_epoch = 1'b0;
    @(negedge clock);
    check("simul_deq_valid", 64'(deq_valid), 64'(0));
    check("simul_count_before", 64'(count), 64'(2));
    @(posedge clock); #1;
    flush = 1'b0; resp_valid = 1'b0;
    sb_q.delete();
    @(negedge clock);
    check("simul_count_after", 64'(count), 64'(0));
    check("simul_epoch", 64'(cur_epoch), 64'(1));
    check("simul_deq_valid_after", 64'(deq_valid), 64'(0));
    @(posedge clock); #1;

    // Asynchronous reset between clock edges with three entries and fault held.
    deq_ready = 1'b0;
    send(32'h500, 1'b0, 1'b1, 1);
    send(32'h504, 1'b0, 1'b1, 1);
    send(32'h508, 1'b1, 1'b1, 1);
    #2;
    check("pre_arst_count", 64'(count), 64'(3));
    check("pre_arst_fault", 64'(fault_hold), 64'(1));
    reset_n = 1'b0;
    #1;
    check("arst_deq_valid", 64'(deq_valid), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    check("arst_fault_hold", 64'(fault_hold), 64'(0));
    check("arst_epoch", 64'(cur_epoch), 64'(0));
    check("arst_resp_ready", 64'(resp_ready), 64'(0));
    sb_q.delete();
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    send(32'h600, 1'b0, 1'b0, 1);
    send(32'h604, 1'b0, 1'b0, 1);
    @(negedge clock);
    check("post_arst_count", 64'(count), 64'(2));
    @(posedge clock); #1;
    drain("post_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
